// File: rtl/div_pkg.sv
// Shared types and sizing for the repeated-subtraction divider controller.
package div_pkg;

  localparam int DIV_W        = 8;
  localparam int DIV_MAX_ITER = 2**DIV_W - 1;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LDN,
    LDP,
    SUB,
    DONE
  } state_t;

endpackage

// File: rtl/div_controller.sv
// Sequencer for the repeated-subtraction divider datapath: clear, load operands, subtract until PgtN drops.
// Latency: quotient Q stops in cycle 4+Q, res_valid from 5+Q; DONE holds until res_ready.
module div_controller
  import div_pkg::*;
#(
  parameter int W        = DIV_W,
  parameter int MAX_ITER = DIV_MAX_ITER
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] Data_out,
  output logic         clear,
  output logic         loadN,
  output logic         loadP,
  output logic         loadS,
  output logic         incQ,
  output logic         stop,
  input  logic         PgtN,
  output logic         busy,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         dbz,
  output logic         ovf
);

  localparam logic [W-1:0] MAX_CNT = W'(MAX_ITER);

  state_t       state_q, state_d;
  logic [W-1:0] dividend_q, dividend_d;
  logic [W-1:0] divisor_q, divisor_d;
  logic [W-1:0] iter_cnt_q, iter_cnt_d;
  logic         dbz_q, dbz_d;
  logic         ovf_q, ovf_d;
  logic         accept;
  logic         div_zero;
  logic         at_limit;

  assign accept   = (state_q == IDLE) && in_valid;
  assign div_zero = (divisor_q == '0);
  assign at_limit = (iter_cnt_q == MAX_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = CLR;
      CLR:  state_d = LDN;
      LDN:  state_d = LDP;
      LDP:  state_d = SUB;
      SUB:  if (div_zero || !PgtN || at_limit) state_d = DONE;
      DONE: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pulses decode purely from state (and PgtN in SUB), so async reset to IDLE silences them at once.
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q != IDLE);
    res_valid = (state_q == DONE);
    Data_out  = '0;
    clear     = 1'b0;
    loadN     = 1'b0;
    loadP     = 1'b0;
    loadS     = 1'b0;
    incQ      = 1'b0;
    stop      = 1'b0;
    case (state_q)
      CLR: clear = 1'b1;
      LDN: begin
        loadN    = 1'b1;
        Data_out = dividend_q;
      end
      LDP: begin
        loadP    = 1'b1;
        Data_out = divisor_q;
      end
      SUB: begin
        if (div_zero || !PgtN || at_limit) begin
          stop = 1'b1;
        end else if (iter_cnt_q == '0) begin
          loadS = 1'b1;
        end else begin
          incQ = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    iter_cnt_d = iter_cnt_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;
    if (accept) begin
      dividend_d = dividend_i;
      divisor_d  = divisor_i;
      iter_cnt_d = '0;
      dbz_d      = 1'b0;
      ovf_d      = 1'b0;
    end else if (state_q == SUB) begin
      if (div_zero) begin
        dbz_d = 1'b1;
      end else if (PgtN && at_limit) begin
        ovf_d = 1'b1;
      end else if (PgtN) begin
        iter_cnt_d = iter_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dividend_q <= '0;
      divisor_q  <= '0;
      iter_cnt_q <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      iter_cnt_q <= iter_cnt_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
    end
  end

  assign dbz = dbz_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_div_controller.sv
// Bench for div_controller with a behavioural divider datapath attached, table vectors plus random ops.
module tb_div_controller;

  logic       clk, rst;
  logic       in_valid, in_ready;
  logic [7:0] dividend_i, divisor_i, Data_out;
  logic       clear, loadN, loadP, loadS, incQ, stop;
  logic       PgtN, busy, res_valid, res_ready, dbz, ovf;

  int checks = 0;
  int errors = 0;

  div_controller #(.W(8), .MAX_ITER(255)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .Data_out(Data_out),
    .clear(clear), .loadN(loadN), .loadP(loadP), .loadS(loadS), .incQ(incQ),
    .stop(stop), .PgtN(PgtN), .busy(busy), .res_valid(res_valid),
    .res_ready(res_ready), .dbz(dbz), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural datapath: N/P registers, quotient counter, result latch; no reset.
  logic [7:0] dpN = 8'd0, dpP = 8'd0, dpQ = 8'd0, Res = 8'd0, Rem = 8'd0;
  bit         force_pgtn = 0;
  assign PgtN = force_pgtn | (dpN >= dpP);

  always @(posedge clk) begin
    if (clear) begin
      dpN <= 8'd0; dpP <= 8'd0; dpQ <= 8'd0;
    end else if (loadN) dpN <= Data_out;
    else if (loadP) dpP <= Data_out;
    else if (loadS || incQ) begin
      dpN <= dpN - dpP; dpQ <= dpQ + 8'd1;
    end
    if (stop) begin
      Res <= dpQ; Rem <= dpN;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // 0 none, 1 clear, 2 loadN, 3 loadP, 4 loadS, 5 incQ, 6 stop, 7 several at once
  function automatic int pcode();
    int n;
    n = int'(clear) + int'(loadN) + int'(loadP) + int'(loadS) + int'(incQ) + int'(stop);
    if (n > 1) return 7;
    if (clear) return 1;
    if (loadN) return 2;
    if (loadP) return 3;
    if (loadS) return 4;
    if (incQ)  return 5;
    if (stop)  return 6;
    return 0;
  endfunction

  function automatic int exp_code(input int c, input int q);
    if (c == 1) return 1;
    if (c == 2) return 2;
    if (c == 3) return 3;
    if (c >= 4 && c < 4 + q) return (c == 4) ? 4 : 5;
    if (c == 4 + q) return 6;
    return 0;
  endfunction

  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    dividend_i = a;
    divisor_i  = b;
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    dividend_i = 8'($urandom);
    divisor_i  = 8'($urandom);
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input bit frc, input int q, input int res, input int rem,
                        input int dbz_e, input int ovf_e, input bit chk_data, input int hold);
    int bad, first_bad, cyc, hold_bad;
    bit got;
    logic [7:0] s_res, s_rem;
    logic s_dbz, s_ovf;
    bad = 0; first_bad = -1; got = 0; cyc = 0;
    force_pgtn = frc;
    start_op(a, b);
    for (int c = 1; c <= 300; c++) begin
      int ed;
      @(negedge clk);
      ed = (c == 2) ? int'(a) : (c == 3) ? int'(b) : 0;
      if (pcode() != exp_code(c, q) || int'(Data_out) != ed || busy !== 1'b1 ||
          in_ready !== 1'b0 || res_valid !== (c == 5 + q)) begin
        bad++;
        if (first_bad < 0) first_bad = c;
      end
      if (res_valid) begin
        got = 1; cyc = c;
        break;
      end
    end
    force_pgtn = 0;
    if (!got) begin
      check({tag, "_timeout"}, 0, 1);
      rst = 1'b1; #2; rst = 1'b0;
      return;
    end
    check({tag, "_trace_bad_cycles"}, bad, 0);
    if (bad != 0) $display("  %s first bad cycle %0d", tag, first_bad);
    check({tag, "_resvalid_cycle"}, cyc, 5 + q);
    check({tag, "_dbz"}, int'(dbz), dbz_e);
    check({tag, "_ovf"}, int'(ovf), ovf_e);
    if (chk_data) begin
      check({tag, "_res"}, int'(Res), res);
      check({tag, "_rem"}, int'(Rem), rem);
    end
    s_res = Res; s_rem = Rem; s_dbz = dbz; s_ovf = ovf;
    hold_bad = 0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || in_ready !== 1'b0 || dbz !== s_dbz || ovf !== s_ovf ||
          Res !== s_res || Rem !== s_rem || pcode() != 0) hold_bad++;
      if (h == 3) begin
        in_valid = 1'b1; dividend_i = 8'd77; divisor_i = 8'd0;
      end
      if (h == 5) in_valid = 1'b0;
    end
    if (hold > 0) check({tag, "_done_hold_bad"}, hold_bad, 0);
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check({tag, "_idle_after_ready"}, int'(in_ready) * 2 + int'(res_valid), 2);
  endtask

  typedef struct {
    logic [7:0] a, b;
    bit         frc;
    int         q, res, rem, dbz_e, ovf_e;
    bit         chk;
  } vec_t;

  vec_t vecs[5];

  initial begin
    rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
    dividend_i = 8'd0; divisor_i = 8'd0;
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_busy_resv", int'(busy) + int'(res_valid), 0);
    check("rst_pulses", pcode(), 0);
    check("rst_data_out", int'(Data_out), 0);
    check("rst_flags", int'(dbz) + int'(ovf), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    vecs[0] = '{8'd100, 8'd7,  1'b0, 14,  14,  2,  0, 0, 1'b1};
    vecs[1] = '{8'd5,   8'd9,  1'b0, 0,   0,   5,  0, 0, 1'b1};
    vecs[2] = '{8'd42,  8'd0,  1'b0, 0,   0,   42, 1, 0, 1'b1};
    vecs[3] = '{8'd255, 8'd1,  1'b0, 255, 255, 0,  0, 0, 1'b1};
    vecs[4] = '{8'd10,  8'd3,  1'b1, 255, 0,   0,  0, 1, 1'b0};
    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].frc, vecs[i].q,
             vecs[i].res, vecs[i].rem, vecs[i].dbz_e, vecs[i].ovf_e, vecs[i].chk, 0);

    // Reset in the middle of the subtraction loop.
    start_op(8'd200, 8'd3);
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_pulses", pcode(), 0);
    check("midrst_busy_resv", int'(busy) + int'(res_valid), 0);
    check("midrst_data_out", int'(Data_out), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_in_ready", int'(in_ready), 1);
    run_op("after_rst", 8'd9, 8'd3, 1'b0, 3, 3, 0, 0, 0, 1'b1, 0);

    // Result held in DONE with res_ready low and stray in_valid.
    run_op("hold", 8'd100, 8'd7, 1'b0, 14, 14, 2, 0, 0, 1'b1, 10);
    run_op("hold_dbz", 8'd42, 8'd0, 1'b0, 0, 0, 42, 1, 0, 1'b1, 10);

    for (int k = 0; k < 24; k++) begin
      logic [7:0] a, b;
      int q, r;
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 12));
      if (b == 0) begin
        q = 0; r = int'(a);
      end else begin
        q = int'(a) / int'(b); r = int'(a) % int'(b);
      end
      run_op($sformatf("rnd%0d", k), a, b, 1'b0, q, q, r, (b == 0) ? 1 : 0, 0, 1'b1,
             int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
